// File: rtl/pwm_meas_pkg.sv
// Shared types and widths for the PWM duty/period measurement block.
package pwm_meas_pkg;

    typedef enum logic [1:0] {WAIT, MEAS, TMO_LO, TMO_HI} meas_state_t;

    localparam int unsigned DUTY_W     = 11;
    localparam int unsigned PER_W      = 12;
    localparam int unsigned PWM_PERIOD = 2048;

    // Highest countable high time; matches the generator's full-scale duty.
    localparam logic [DUTY_W-1:0] HI_MAX  = DUTY_W'(PWM_PERIOD - 1);
    localparam logic [PER_W-1:0]  PER_MAX = '1;

endpackage

// File: rtl/pwm_duty_meas_if.sv
// PWM line in, measurement results out; slave is the measuring block.
interface pwm_duty_meas_if;
    import pwm_meas_pkg::*;

    logic              pwm_in;
    logic [DUTY_W-1:0] duty;
    logic [PER_W-1:0]  period;
    logic              meas_vld;
    logic              locked;
    logic              stuck_hi;

    modport master (output pwm_in, input duty, period, meas_vld, locked, stuck_hi);
    modport slave  (input pwm_in, output duty, period, meas_vld, locked, stuck_hi);

endinterface

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for the asynchronous PWM pin plus a delay flop for edge detection.
module pwm_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_i,
    output logic pwm_s_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic pwm_s_q;
    logic pwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            pwm_s_q <= 1'b0;
            pwm_q   <= 1'b0;
        end else begin
            sync1_q <= pwm_i;
            pwm_s_q <= sync1_q;
            pwm_q   <= pwm_s_q;
        end
    end

    assign pwm_s_o = pwm_s_q;
    assign rise_o  = pwm_s_q & ~pwm_q;
    assign fall_o  = ~pwm_s_q & pwm_q;

endmodule

// File: rtl/pwm_duty_meas.sv
// Measures high time and rise-to-rise period of a PWM line; flags 0% duty and stuck-high.
module pwm_duty_meas
    import pwm_meas_pkg::*;
#(
    parameter logic [PER_W-1:0] TIMEOUT = 12'd3072
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_duty_meas_if.slave meas_if
);

    logic pwm_s, rise, fall, tmo;

    meas_state_t       state_q, state_d;
    logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
    logic [DUTY_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic              meas_vld_q, meas_vld_d;
    logic              locked_q, locked_d;
    logic              stuck_hi_q, stuck_hi_d;

    pwm_sync_edge u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_i   (meas_if.pwm_in),
        .pwm_s_o (pwm_s),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    assign tmo = (per_cnt_q == TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT;
        else        state_q <= state_d;
    end

    // A rise always wins over a coincident timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT, MEAS: begin
                if (rise)     state_d = MEAS;
                else if (tmo) state_d = pwm_s ? TMO_HI : TMO_LO;
            end
            TMO_LO: if (rise) state_d = MEAS;
            TMO_HI: if (fall) state_d = WAIT;
            default: state_d = WAIT;
        endcase
    end

    always_comb begin
        per_cnt_d  = (per_cnt_q == PER_MAX) ? per_cnt_q : per_cnt_q + 12'd1;
        hi_cnt_d   = (pwm_s && hi_cnt_q != HI_MAX) ? hi_cnt_q + 11'd1 : hi_cnt_q;
        duty_d     = duty_q;
        period_d   = period_q;
        meas_vld_d = 1'b0;
        locked_d   = locked_q;
        stuck_hi_d = stuck_hi_q;
        unique case (state_q)
            WAIT, MEAS: begin
                if (rise) begin
                    // Counters restart at 1 so a full rise-to-rise interval counts exactly.
                    per_cnt_d = 12'd1;
                    hi_cnt_d  = 11'd1;
                    if (state_q == MEAS) begin
                        duty_d     = hi_cnt_q;
                        period_d   = per_cnt_q;
                        meas_vld_d = 1'b1;
                        locked_d   = 1'b1;
                    end
                end else if (tmo) begin
                    duty_d     = pwm_s ? HI_MAX : '0;
                    period_d   = '0;
                    meas_vld_d = 1'b1;
                    locked_d   = 1'b0;
                    stuck_hi_d = pwm_s;
                end
            end
            TMO_LO: begin
                if (rise) begin
                    per_cnt_d = 12'd1;
                    hi_cnt_d  = 11'd1;
                end
            end
            TMO_HI: begin
                if (fall) begin
                    per_cnt_d  = '0;
                    hi_cnt_d   = '0;
                    stuck_hi_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_q  <= '0;
            hi_cnt_q   <= '0;
            duty_q     <= '0;
            period_q   <= '0;
            meas_vld_q <= 1'b0;
            locked_q   <= 1'b0;
            stuck_hi_q <= 1'b0;
        end else begin
            per_cnt_q  <= per_cnt_d;
            hi_cnt_q   <= hi_cnt_d;
            duty_q     <= duty_d;
            period_q   <= period_d;
            meas_vld_q <= meas_vld_d;
            locked_q   <= locked_d;
            stuck_hi_q <= stuck_hi_d;
        end
    end

    assign meas_if.duty     = duty_q;
    assign meas_if.period   = period_q;
    assign meas_if.meas_vld = meas_vld_q;
    assign meas_if.locked   = locked_q;
    assign meas_if.stuck_hi = stuck_hi_q;

endmodule

// File: tb/tb_pwm_duty_meas.sv
// Drives a PWM generator (plus forced-high and reset events) and checks every cycle against
// a waveform-level model: measurements are derived from the recorded pin history.
module tb_pwm_duty_meas;
    import pwm_meas_pkg::*;

    localparam logic [11:0] TMO   = 12'd3072;
    localparam int          TMO_I = 3072;
    localparam int          LAT   = 2;  // pin sample edge -> output edge

    typedef struct {
        int at;
        int kind;  // 0 measurement, 1 timeout low, 2 timeout high, 3 stuck-high release
        int duty;
        int per;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    pwm_duty_meas_if mif ();

    pwm_duty_meas #(.TIMEOUT(TMO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .meas_if (mif)
    );

    always #5 clk = ~clk;

    int  n_assert = 0;
    int  n_fail   = 0;
    int  gen_duty = 0;
    int  gen_phase = 0;
    bit  force_hi = 1'b0;
    bit  hist [65536];
    int  t;
    bit  prev_pin;
    bit  have_ref, armed, in_hi_tmo;
    int  anchor, last_rise;
    int  first_vld_t;
    ev_t evq[$];
    int  e_duty, e_per;
    bit  e_vld, e_locked, e_stuck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at t=%0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_init();
        t = 0; prev_pin = 1'b0; have_ref = 1'b0; armed = 1'b1; in_hi_tmo = 1'b0;
        anchor = -2; last_rise = 0; first_vld_t = -1; evq.delete();
        e_duty = 0; e_per = 0; e_vld = 1'b0; e_locked = 1'b0; e_stuck = 1'b0;
    endtask

    // One clock: drive pin, update model, sample outputs just after the edge.
    task automatic step();
        bit pin, rise, fall;
        int s;
        pin  = force_hi ? 1'b1 : (gen_phase < gen_duty);
        mif.pwm_in = pin;
        hist[t % 65536] = pin;
        rise = pin & ~prev_pin;
        fall = ~pin & prev_pin;
        if (in_hi_tmo) begin
            if (fall) begin
                in_hi_tmo = 1'b0; armed = 1'b1; have_ref = 1'b0; anchor = t + 1;
                evq.push_back('{t + LAT, 3, 0, 0});
            end
        end else if (rise) begin
            if (have_ref) begin
                s = 0;
                for (int k = last_rise; k < t; k++) s += int'(hist[k % 65536]);
                evq.push_back('{t + LAT, 0, (s > 2047) ? 2047 : s, t - last_rise});
            end
            have_ref = 1'b1; armed = 1'b1; anchor = t; last_rise = t;
        end else if (armed && t == anchor + TMO_I) begin
            armed = 1'b0; have_ref = 1'b0; in_hi_tmo = pin;
            evq.push_back('{t + LAT, pin ? 2 : 1, 0, 0});
        end
        prev_pin  = pin;
        gen_phase = (gen_phase + 1) % 2048;

        @(posedge clk);
        #1;
        e_vld = 1'b0;
        while (evq.size() > 0 && evq[0].at == t) begin
            case (evq[0].kind)
                0: begin e_duty = evq[0].duty; e_per = evq[0].per; e_locked = 1'b1; e_vld = 1'b1; end
                1: begin e_duty = 0; e_per = 0; e_locked = 1'b0; e_vld = 1'b1; end
                2: begin e_duty = 2047; e_per = 0; e_locked = 1'b0; e_stuck = 1'b1; e_vld = 1'b1; end
                default: e_stuck = 1'b0;
            endcase
            void'(evq.pop_front());
        end
        if (mif.meas_vld === 1'b1 && first_vld_t < 0) first_vld_t = t;
        chk("meas_vld", 32'(mif.meas_vld), 32'(e_vld));
        chk("duty",     32'(mif.duty),     32'(e_duty));
        chk("period",   32'(mif.period),   32'(e_per));
        chk("locked",   32'(mif.locked),   32'(e_locked));
        chk("stuck_hi", 32'(mif.stuck_hi), 32'(e_stuck));
        t++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        chk("rst_duty",     32'(mif.duty),     32'h0);
        chk("rst_period",   32'(mif.period),   32'h0);
        chk("rst_meas_vld", 32'(mif.meas_vld), 32'h0);
        chk("rst_locked",   32'(mif.locked),   32'h0);
        chk("rst_stuck_hi", 32'(mif.stuck_hi), 32'h0);
        repeat (n) begin
            @(negedge clk);
            gen_phase = (gen_phase + 1) % 2048;
        end
        rst_n = 1'b1;
        model_init();
    endtask

    initial begin
        mif.pwm_in = 1'b0;
        model_init();
        @(negedge clk);
        do_reset(3);

        // Steady duty 400 from a random phase.
        gen_duty  = 400;
        gen_phase = $urandom_range(0, 2047);
        run(5 * 2048);
        chk("locked_400", 32'(mif.locked), 32'h1);

        // Extremes of duty.
        gen_duty = 1;
        run(3 * 2048);
        gen_duty = 2047;
        run(3 * 2048);

        // Duty change partway through a period.
        gen_duty = 400;
        run(2 * 2048 + $urandom_range(100, 1900));
        gen_duty = 1000;
        run(4 * 2048);
        chk("duty_1000", 32'(mif.duty), 32'd1000);

        // 0% duty from reset, then recovery.
        gen_duty = 0;
        do_reset(4);
        run(TMO_I + 20);
        chk("tmo_lo_time", 32'(first_vld_t), 32'(TMO_I));
        chk("tmo_lo_locked", 32'(mif.locked), 32'h0);
        gen_duty = 500;
        run(3 * 2048);
        chk("duty_500", 32'(mif.duty), 32'd500);

        // Line stuck high, then released.
        force_hi = 1'b1;
        run(4000);
        chk("stuck_hi_set", 32'(mif.stuck_hi), 32'h1);
        chk("stuck_duty",   32'(mif.duty),     32'h7FF);
        force_hi = 1'b0;
        run(3000);

        // Reset pulse mid-period at duty 700.
        gen_duty = 700;
        run(2048 + $urandom_range(200, 1800));
        do_reset(5);
        run(3 * 2048);
        chk("duty_700", 32'(mif.duty), 32'd700);

        // Random duty sequence.
        for (int i = 0; i < 5; i++) begin
            gen_duty = $urandom_range(1, 2047);
            run($urandom_range(1500, 4000));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_duty_meas.md
Name: pwm_duty_meas

Overview:
Measures an incoming 11-bit-resolution PWM waveform: its high time and its period, in clk cycles. It is the receive end of the motor PWM generator and is used by the motor/plant model and by self-check logic to recover the commanded duty from the pin. It also detects 0% duty (line held low) and a stuck-high fault.

Parameters:
TIMEOUT, 12'd3072, number of cycles without a rising edge before timeout is declared. Legal range is 2049..4095.

Ports:
clk  input  1  system clock; same clock domain as the generator.
rst_n  input  1  reset, asynchronous, active-low.
pwm_in  input  1  PWM line; treated as asynchronous.
duty  output  11  last measured high time in cycles. Reset value 11'h000.
period  output  12  last measured rise-to-rise period in cycles. Reset value 12'h000.
meas_vld  output  1  one-cycle pulse when duty/period update. Reset value 0.
locked  output  1  high while in MEAS after at least one full period has been measured. Reset value 0.
stuck_hi  output  1  high while the line has been high for TIMEOUT cycles. Reset value 0.

Behaviour:
- Input path: two-flop synchronizer gives pwm_s; a delay flop gives pwm_q.
  - rise = pwm_s & ~pwm_q; fall = ~pwm_s & pwm_q.
  - A pin edge in cycle N is detected in cycle N+2; the outputs change at N+3.
- Counters:
  - per_cnt (12 bit) increments every cycle and saturates at 4095.
  - hi_cnt (11 bit) increments on cycles where pwm_s=1 and saturates at 2047.
  - On rise, both counters load 1, not 0, so that a rise-to-rise interval yields exact counts.
  - With the generator at duty D (1..2047): period=2048 and duty=D.
- FSM states: WAIT, MEAS, TMO_LO, TMO_HI. Reset state is WAIT with both counters at 0.
- WAIT:
  - rise -> MEAS; counters load 1; no meas_vld, because the first partial period is discarded.
  - per_cnt==TIMEOUT -> TMO_LO if pwm_s=0, TMO_HI if pwm_s=1.
- MEAS:
  - rise -> register duty<=hi_cnt and period<=per_cnt; pulse meas_vld; set locked; counters load 1; stay in MEAS.
  - per_cnt==TIMEOUT -> TMO_LO or TMO_HI as in WAIT; locked<=0.
- TMO_LO (0% duty):
  - On entry: duty<=0, period<=0, one meas_vld pulse, locked<=0.
  - rise -> MEAS with counters loaded 1; the next rise produces a valid measurement.
- TMO_HI:
  - On entry: stuck_hi<=1, duty<=11'h7FF, period<=0, one meas_vld pulse, locked<=0.
  - fall -> WAIT with stuck_hi<=0 and counters cleared.
- Simultaneous rise and per_cnt==TIMEOUT in the same cycle: rise wins and is processed as a normal measurement.
- Duty change mid-period: the period in progress reports mixed high time. The first full period after the change reports the new value exactly.
- Reset asserted mid-operation: all flops, including the synchronizer, return to reset values immediately; the FSM returns to WAIT.
- Glitch filtering: none. Every synchronized rise restarts the period.

Decomposition:
- Package pwm_meas_pkg:
  - typedef enum logic [1:0] {WAIT, MEAS, TMO_LO, TMO_HI} meas_state_t.
  - localparam DUTY_W=11, PER_W=12, PWM_PERIOD=2048.
- Sub-module pwm_sync_edge: 2-flop synchronizer plus delay flop; outputs pwm_s, rise, fall. Asynchronous reset to 0.
- Top level: counters, FSM and output registers.

Test Plan:
- Generator at duty=400 -> first meas_vld at the second detected rise; duty=400, period=2048; meas_vld every 2048 cycles; locked=1 after the first pulse.
- Generator at duty=1 and duty=2047 -> duty=1 / 2047 and period=2048 each period; no timeout.
- Duty changed 400->1000 mid-period -> one mixed report, then duty=1000 steadily.
- Duty=0 from reset -> meas_vld with duty=0 and period=0 exactly TIMEOUT+1 cycles after reset release; locked=0; then duty=500 -> duty=500 after two rises.
- pwm_in forced high for 4000 cycles -> stuck_hi=1 and duty=11'h7FF after TIMEOUT; release -> stuck_hi=0 two cycles later; state WAIT.
- rst_n pulsed low mid-period at duty=700 -> outputs read 0 during reset; after release no meas_vld until the second rise, then duty=700.
